// File: rtl/mul_pkg.sv
// mul_pkg -- shared definitions for the shift-and-add multiplier.
//   MUL_WIDTH_DEF : default operand width in bits
//   mul_state_e   : controller states (IDLE, RUN, FIN)
package mul_pkg;

  localparam int MUL_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } mul_state_e;

endpackage

// File: rtl/shift_add_dp.sv
// shift_add_dp -- datapath of the shift-and-add multiplier.
// Holds the multiplicand (zero-extended to 2*WIDTH), the multiplier and the
// accumulator. Each step conditionally adds the multiplicand, then shifts
// the multiplicand left and the multiplier right.
//   clk_i            : clock, rising edge
//   rst_i            : synchronous active-high reset, clears all registers
//   load_i           : capture a_i/b_i and clear the accumulator
//   step_i           : perform one iteration
//   a_i, b_i         : unsigned operands
//   acc_next_o       : accumulator value after the current iteration
//   mplr_next_zero_o : multiplier is zero after the current shift
module shift_add_dp
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   acc_next_o,
  output logic                 mplr_next_zero_o
);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0]   mplr_q,  mplr_d;

  // Full 2*WIDTH add: the product of two WIDTH-bit values always fits.
  always_comb begin
    acc_d   = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
    mcand_d = mcand_q << 1;
    mplr_d  = mplr_q >> 1;
  end

  assign acc_next_o       = acc_d;
  assign mplr_next_zero_o = (mplr_d == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
    end else if (load_i) begin
      mcand_q <= {{WIDTH{1'b0}}, a_i};
      mplr_q  <= b_i;
      acc_q   <= '0;
    end else if (step_i) begin
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: rtl/shift_add_mul.sv
// shift_add_mul -- sequential unsigned multiplier, one iteration per clock.
// START is accepted in IDLE or FIN; the product appears on P with DONE high
// WIDTH cycles after acceptance, and stays until the next accepted START.
// Build option: define SHIFT_ADD_MUL_EARLY_TERM_EN to stop iterating as soon
// as the remaining multiplier bits are all zero (same product, lower latency).
//   CK    : clock, rising edge
//   RST   : synchronous active-high reset
//   START : request a multiply (ignored while BUSY)
//   A, B  : unsigned operands, sampled with START
//   BUSY  : iteration sequence in progress
//   DONE  : P holds a fresh result
//   P     : product A*B, 2*WIDTH bits
module shift_add_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [2*WIDTH-1:0]   P
);

`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mul_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               done_q,  done_d;
  logic [2*WIDTH-1:0] p_q,     p_d;

  logic               accept;
  logic               step;
  logic               last;
  logic [2*WIDTH-1:0] acc_next;
  logic               mplr_next_zero;

  // FIN behaves like IDLE for acceptance; RUN ignores START entirely.
  assign accept = START && (state_q != ST_RUN);
  assign step   = (state_q == ST_RUN);
  assign last   = (cnt_q == LAST_CNT) || (EARLY_TERM && mplr_next_zero);

  shift_add_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk_i            (CK),
    .rst_i            (RST),
    .load_i           (accept),
    .step_i           (step),
    .a_i              (A),
    .b_i              (B),
    .acc_next_o       (acc_next),
    .mplr_next_zero_o (mplr_next_zero)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    p_d     = p_q;
    unique case (state_q)
      ST_IDLE, ST_FIN: begin
        if (START) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          // Capture the accumulator including this final iteration.
          state_d = ST_FIN;
          p_d     = acc_next;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      p_q     <= p_d;
    end
  end

  assign BUSY = (state_q == ST_RUN);
  assign DONE = done_q;
  assign P    = p_q;

endmodule

// File: tb/tb_shift_add_mul.sv
module tb_shift_add_mul;

`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        ck = 1'b0;
  logic        rst;
  logic        start16, start8;
  logic [15:0] a16, b16;
  logic [7:0]  a8, b8;
  logic        busy16, done16, busy8, done8;
  logic [31:0] p16;
  logic [15:0] p8;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_p16;

  always #5 ck = ~ck;

  shift_add_mul #(.WIDTH(16)) u16 (
    .CK(ck), .RST(rst), .START(start16), .A(a16), .B(b16),
    .BUSY(busy16), .DONE(done16), .P(p16)
  );

  shift_add_mul #(.WIDTH(8)) u8 (
    .CK(ck), .RST(rst), .START(start8), .A(a8), .B(b8),
    .BUSY(busy8), .DONE(done8), .P(p8)
  );

  // Reference latency: WIDTH iterations, or up to and including the highest
  // set bit of B when early termination is built in (1 when B is zero).
  function automatic int exp_lat(input logic [31:0] b, input int w);
    if (!EARLY) return w;
    for (int i = w - 1; i >= 0; i--)
      if (b[i]) return i + 1;
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One multiply on the 16-bit instance, optionally with a stray START
  // (A=7, B=9) raised during the third RUN cycle.
  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       input string tag, input bit inj);
    int lat;
    bit busy_ok;
    logic [31:0] exp_p;
    exp_p = 32'(a) * 32'(b);
    @(negedge ck);
    start16 = 1'b1; a16 = a; b16 = b;
    @(negedge ck);
    start16 = 1'b0; a16 = $urandom; b16 = $urandom;
    chk({tag, " done_drop"}, 64'(done16), 64'd0);
    chk({tag, " p_held"},    64'(p16),    64'(last_p16));
    chk({tag, " busy_on"},   64'(busy16), 64'd1);
    lat = 0; busy_ok = 1'b1;
    while (done16 !== 1'b1 && lat < 200) begin
      if (busy16 !== 1'b1) busy_ok = 1'b0;
      @(negedge ck);
      lat++;
      if (inj && lat == 2) begin
        start16 = 1'b1; a16 = 16'd7; b16 = 16'd9;
      end else begin
        start16 = 1'b0;
      end
    end
    start16 = 1'b0;
    chk({tag, " latency"},  64'(lat),     64'(exp_lat(32'(b), 16)));
    chk({tag, " product"},  64'(p16),     64'(exp_p));
    chk({tag, " busy_off"}, 64'(busy16),  64'd0);
    chk({tag, " busy_run"}, 64'(busy_ok), 64'd1);
    last_p16 = exp_p;
  endtask

  initial begin
    int lat;
    logic [15:0] ra, rb;

    rst = 1'b1; start16 = 1'b0; start8 = 1'b0;
    a16 = '0; b16 = '0; a8 = '0; b8 = '0;
    last_p16 = '0;
    repeat (2) @(negedge ck);
    chk("reset p16",    64'(p16),    64'd0);
    chk("reset done16", 64'(done16), 64'd0);
    chk("reset busy16", 64'(busy16), 64'd0);
    chk("reset p8",     64'(p8),     64'd0);
    rst = 1'b0;

    run16(16'd2,     16'd255,   "2x255",     1'b0);
    run16(16'hFFFF,  16'hFFFF,  "ffffxffff", 1'b0);
    run16(16'd1234,  16'd0,     "1234x0",    1'b0);
    run16(16'd5,     16'd6,     "5x6_inj",   1'b1);
    repeat (3) @(negedge ck);
    chk("inj ignored p",    64'(p16),    64'd30);
    chk("inj ignored done", 64'(done16), 64'd1);
    chk("inj ignored busy", 64'(busy16), 64'd0);

    // Reset in the middle of a RUN abandons it.
    @(negedge ck);
    start16 = 1'b1; a16 = 16'd100; b16 = 16'd200;
    @(negedge ck);
    start16 = 1'b0;
    repeat (2) @(negedge ck);
    rst = 1'b1; start16 = 1'b1; a16 = 16'd9; b16 = 16'd9;
    @(negedge ck);
    rst = 1'b0; start16 = 1'b0;
    chk("midrst p",    64'(p16),    64'd0);
    chk("midrst done", 64'(done16), 64'd0);
    chk("midrst busy", 64'(busy16), 64'd0);
    repeat (20) @(negedge ck);
    chk("midrst no_result", 64'(done16), 64'd0);
    last_p16 = '0;
    run16(16'd3, 16'd4, "3x4", 1'b0);

    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom) >> $urandom_range(0, 15);
      run16(ra, rb, "rand", 1'b0);
    end

    // Back-to-back from FIN on the 8-bit instance.
    @(negedge ck);
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd200;
    @(negedge ck);
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 100) begin @(negedge ck); lat++; end
    chk("w8 200x200 latency", 64'(lat), 64'(exp_lat(32'd200, 8)));
    chk("w8 200x200 product", 64'(p8),  64'd40000);
    @(negedge ck);
    start8 = 1'b1; a8 = 8'd15; b8 = 8'd17;
    @(negedge ck);
    start8 = 1'b0;
    chk("w8 done_drop", 64'(done8), 64'd0);
    chk("w8 p_held",    64'(p8),    64'd40000);
    chk("w8 busy_on",   64'(busy8), 64'd1);
    lat = 0;
    while (done8 !== 1'b1 && lat < 100) begin @(negedge ck); lat++; end
    chk("w8 15x17 latency", 64'(lat), 64'(exp_lat(32'd17, 8)));
    chk("w8 15x17 product", 64'(p8),  64'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
